// File: rtl/led_pkg.sv
// Shared types and constants for the LED-matrix blocks.
package led_pkg;

  // One 16x16 single-colour frame: [row][column].
  typedef logic [15:0][15:0] frame_t;

  // Arbiter states; grant is decoded straight from these.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } arb_state_t;

  // Number of frame sources sharing the matrix.
  localparam int NUM_SRC = 2;

endpackage : led_pkg

// File: rtl/led_frame_arbiter_dwell_timer.sv
// Saturating dwell counter: cleared on every arbiter state entry, counts
// while a source is being served, and flags when the minimum dwell is met.
module led_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int unsigned W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [W-1:0] CNT_LAST = W'(DWELL_CYCLES - 1);

  logic [W-1:0] cnt;

  // Count up while enabled, hold at CNT_LAST; clear has priority.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // With DWELL_CYCLES=1 CNT_LAST is 0, so done is true on the first cycle.
  assign done = (cnt == CNT_LAST);

endmodule : led_dwell_timer

// File: rtl/led_frame_arbiter.sv
// Two-source round-robin arbiter for the shared 16x16 red/green LED matrix.
// The granted source's frames are registered onto RedPixels/GrnPixels.
module led_frame_arbiter
  import led_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] req,
  input  frame_t             red_in0,
  input  frame_t             grn_in0,
  input  frame_t             red_in1,
  input  frame_t             grn_in1,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output frame_t             RedPixels,
  output frame_t             GrnPixels
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       dwell_done;
  logic       entering;

  // Next-state decision; kept combinational so the dwell timer can be
  // cleared on the very edge that enters a new state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_nxt = SERVE0;
          2'b10:   state_nxt = SERVE1;
          2'b11:   state_nxt = last ? SERVE0 : SERVE1;
          default: state_nxt = IDLE;
        endcase
      end
      SERVE0: begin
        if (!req[0]) begin
          state_nxt = req[1] ? SERVE1 : IDLE;
        end else if (dwell_done && req[1]) begin
          state_nxt = SERVE1;
        end
      end
      SERVE1: begin
        if (!req[1]) begin
          state_nxt = req[0] ? SERVE0 : IDLE;
        end else if (dwell_done && req[0]) begin
          state_nxt = SERVE0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign entering = (state_nxt != state);

  led_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk  (clk),
    .RST  (RST),
    .clear(entering),
    .en   (state != IDLE),
    .done (dwell_done)
  );

  // State register and round-robin pointer; last records the source just entered.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == SERVE0) begin
        last <= 1'b0;
      end else if (state_nxt == SERVE1) begin
        last <= 1'b1;
      end
    end
  end

  // Grant decoded from the state register only, so it is glitch-free.
  always_comb begin
    grant = '0;
    case (state)
      SERVE0:  grant = 2'b01;
      SERVE1:  grant = 2'b10;
      default: grant = '0;
    endcase
  end

  assign busy = |grant;

  // Pixel registers follow the current grant, blank when nobody owns the matrix.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      RedPixels <= '0;
      GrnPixels <= '0;
    end else begin
      case (grant)
        2'b01: begin
          RedPixels <= red_in0;
          GrnPixels <= grn_in0;
        end
        2'b10: begin
          RedPixels <= red_in1;
          GrnPixels <= grn_in1;
        end
        default: begin
          RedPixels <= '0;
          GrnPixels <= '0;
        end
      endcase
    end
  end

endmodule : led_frame_arbiter
